// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Contents: XLEN, reset PC / NOP defaults, fetch FSM state enum, word-align helper.
// Optional feature macro used by users of this package: IF_MISALIGN_CHECK_EN.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC selector for if_fetch: flush > branch > PC+4, result word-aligned.
// Ports:
//   flush_i/flush_addr_i    later-stage flush and its target
//   branch_i/branch_addr_i  decode redirect and its target
//   pc_i                    PC of the held instruction (base for PC+4)
//   next_pc_o               selected target with bits [1:0] cleared
//   misalign_o              selected target had nonzero [1:0]
//                           (only with IF_MISALIGN_CHECK_EN)
module if_pc_sel
  import if_pkg::*;
(
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] next_pc_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  logic [XLEN-1:0] target;

  // Priority mux; PC+4 wraps naturally at 32 bits.
  always_comb begin
    target = pc_i + XLEN'(4);
    if (flush_i) begin
      target = flush_addr_i;
    end else if (branch_i) begin
      target = branch_addr_i;
    end
  end

  assign next_pc_o = align_word(target);

`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_o = |target[1:0];
`endif

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem req/ack handshake
// and holds one fetched instruction (with its PC) until decode takes it.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/imem_addr           fetch request and word-aligned address
//   imem_ack/imem_rdata          memory response and instruction word
//   id_ready_i                   decode accepts the held instruction
//   branch_i/branch_addr_i       decode redirect (honoured only while holding)
//   flush_i/flush_addr_i         later-stage flush, any state
//   pc_o/inst_o/inst_valid_o     held instruction to decode (NOP when invalid)
//   misalign_o                   sticky misaligned-target flag
//                                (only with IF_MISALIGN_CHECK_EN)
module if_fetch
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_ready_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            inst_valid_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] next_pc;
  logic            take;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_c;
  logic misalign_q, misalign_d;
`endif

  // branch_i is passed unqualified: the target is only taken from S_HOLD with
  // id_ready_i, or on a flush which outranks it inside the selector.
  if_pc_sel u_pc_sel (
    .flush_i      (flush_i),
    .flush_addr_i (flush_addr_i),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .pc_i         (pc_out_q),
    .next_pc_o    (next_pc)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .misalign_o   (misalign_c)
`endif
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pc_out_q   <= RESET_PC;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pc_out_q   <= pc_out_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    take     = 1'b0;

    case (state_q)
      S_REQ: begin
        if (flush_i) begin
          // With ack the request is complete and its data is dropped;
          // without ack the old request must still be carried to completion.
          take    = 1'b1;
          state_d = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          inst_d   = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_DROP: begin
        if (flush_i) begin
          take = 1'b1;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (flush_i || id_ready_i) begin
          take    = 1'b1;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end
      end
`ifdef IF_MISALIGN_CHECK_EN
      S_ERR: begin
        if (flush_i) begin
          take    = 1'b1;
          state_d = S_REQ;
        end
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (take) begin
      pc_d = next_pc;
    end

`ifdef IF_MISALIGN_CHECK_EN
    if (take && misalign_c) begin
      state_d = S_ERR;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
    misalign_d = (state_d == S_ERR);
`endif

    // The issued address is frozen except when a new request begins.
    req_addr_d = (state_d == S_REQ) ? pc_d : req_addr_q;
  end

  assign imem_req     = !rst && ((state_q == S_REQ) || (state_q == S_DROP));
  assign imem_addr    = align_word(req_addr_q);
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`endif

endmodule
